// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph table,
// FSM state encoding and the default stability threshold.
package seg_scan_decoder_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_e;

  // Lit patterns (1 = segment on), bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // True when exactly one active-low anode is asserted
  function automatic logic one_low(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Digit index of the single low anode (only meaningful when one_low)
  function automatic logic [1:0] digit_idx(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!an[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational lit-pattern to hex nibble decoder with illegal-glyph flag.
module seg7_to_hex
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] lit_i,
  output logic [3:0] nib_o,
  output logic       bad_o
);

  // Table lookup; anything outside the 16 glyphs is flagged
  always_comb begin
    nib_o = 4'h0;
    bad_o = 1'b0;
    case (lit_i)
      GLYPH_0: nib_o = 4'h0;
      GLYPH_1: nib_o = 4'h1;
      GLYPH_2: nib_o = 4'h2;
      GLYPH_3: nib_o = 4'h3;
      GLYPH_4: nib_o = 4'h4;
      GLYPH_5: nib_o = 4'h5;
      GLYPH_6: nib_o = 4'h6;
      GLYPH_7: nib_o = 4'h7;
      GLYPH_8: nib_o = 4'h8;
      GLYPH_9: nib_o = 4'h9;
      GLYPH_A: nib_o = 4'hA;
      GLYPH_B: nib_o = 4'hB;
      GLYPH_C: nib_o = 4'hC;
      GLYPH_D: nib_o = 4'hD;
      GLYPH_E: nib_o = 4'hE;
      GLYPH_F: nib_o = 4'hF;
      default: bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiving end of a multiplexed seven-segment bus: debounces each selected
// digit, decodes it, and publishes a 16-bit value once all four are seen.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        digit_err
);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  ref_an_q;
  logic [6:0]  ref_seg_q;
  logic [15:0] shadow_q;
  logic [3:0]  mask_q;
  logic [15:0] value_q;
  logic        valid_q;
  logic        err_q;

  logic        sel;
  logic        same;
  logic [8:0]  cnt_inc;
  logic        cap;
  logic [1:0]  dig;
  logic [3:0]  nib;
  logic        bad;
  logic [15:0] shadow_d;
  logic [3:0]  mask_d;

  assign sel     = one_low(an);
  assign same    = (an == ref_an_q) && (seg == ref_seg_q);
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  // Capture fires on the cycle the run of identical samples hits the threshold
  assign cap     = (state_q == ST_SETTLE) && same && (cnt_inc == 9'(STABLE_CYCLES));
  assign dig     = digit_idx(ref_an_q);

  seg7_to_hex u_dec (
    .lit_i (~ref_seg_q),
    .nib_o (nib),
    .bad_o (bad)
  );

  // Shadow/mask as they would look with the current capture merged in
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[{dig, 2'b00} +: 4] = nib;
    mask_d = mask_q | (4'b0001 << dig);
  end

  // Stability FSM: tracks the reference pattern and run length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      ref_an_q  <= 4'h0;
      ref_seg_q <= 7'h00;
    end else begin
      case (state_q)
        ST_IDLE: if (sel) begin
          state_q   <= ST_SETTLE;
          cnt_q     <= 8'd1;
          ref_an_q  <= an;
          ref_seg_q <= seg;
        end
        ST_SETTLE: begin
          if (!sel) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else if (same) begin
            cnt_q <= cnt_inc[7:0];
            if (cap) state_q <= ST_HELD;
          end else begin
            cnt_q     <= 8'd1;
            ref_an_q  <= an;
            ref_seg_q <= seg;
          end
        end
        ST_HELD: if (!same) begin
          if (sel) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= 8'd1;
            ref_an_q  <= an;
            ref_seg_q <= seg;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Round assembly: merge captures, publish full rounds, drop bad rounds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= 16'h0000;
      mask_q   <= 4'h0;
      value_q  <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (cap) begin
        if (bad) begin
          err_q    <= 1'b1;
          mask_q   <= 4'h0;
          shadow_q <= 16'h0000;
        end else if (mask_d == 4'hF) begin
          value_q  <= shadow_d;
          valid_q  <= 1'b1;
          mask_q   <= 4'h0;
          shadow_q <= shadow_d;
        end else begin
          mask_q   <= mask_d;
          shadow_q <= shadow_d;
        end
      end
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign digit_err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-derived expectations.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] value;
  logic        value_valid;
  logic        digit_err;

  int n_chk = 0;
  int n_err = 0;
  int vcnt  = 0;
  int ecnt  = 0;
  int v0, e0;
  logic [6:0] gl [16];

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .value_valid (value_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (value_valid) vcnt <= vcnt + 1;
    if (digit_err)   ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] lit, input int n);
    an  = ~(4'b0001 << d);
    seg = ~lit;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    an  = 4'hF;
    seg = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int d, input logic [3:0] h);
    show(d, gl[h], 8);
    blank(2);
  endtask

  task automatic scan(input logic [15:0] v);
    for (int d = 3; d >= 0; d--) dig(d, v[4*d +: 4]);
  endtask

  initial begin
    gl[0]  = 7'b1111110; gl[1]  = 7'b0110000; gl[2]  = 7'b1101101; gl[3]  = 7'b1111001;
    gl[4]  = 7'b0110011; gl[5]  = 7'b1011011; gl[6]  = 7'b1011111; gl[7]  = 7'b1110000;
    gl[8]  = 7'b1111111; gl[9]  = 7'b1111011; gl[10] = 7'b1110111; gl[11] = 7'b0011111;
    gl[12] = 7'b1001110; gl[13] = 7'b0111101; gl[14] = 7'b1001111; gl[15] = 7'b1000111;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_valid", 32'(value_valid), 32'h0);
    chk("rst_err",   32'(digit_err), 32'h0);
    rst = 1'b0;
    blank(2);

    // Basic scans
    v0 = vcnt; e0 = ecnt;
    scan(16'h1234);
    chk("scan1234_value", 32'(value), 32'h1234);
    chk("scan1234_pulses", 32'(vcnt - v0), 32'd1);
    chk("scan1234_err", 32'(ecnt - e0), 32'd0);
    v0 = vcnt;
    scan(16'h9876);
    chk("scan9876_value", 32'(value), 32'h9876);
    chk("scan9876_pulses", 32'(vcnt - v0), 32'd1);

    // Glyph 8 held 3 cycles then 0 held 4: only the 0 lands
    v0 = vcnt;
    dig(3, 4'hF); dig(2, 4'hE); dig(1, 4'h5);
    show(0, gl[8], 3);
    show(0, gl[0], 4);
    blank(2);
    chk("short8_value", 32'(value), 32'hFE50);
    chk("short8_pulses", 32'(vcnt - v0), 32'd1);

    // Two anodes low counts as blanking
    v0 = vcnt; e0 = ecnt;
    dig(3, 4'h4); dig(2, 4'h2);
    an = 4'b1100; seg = ~gl[8];
    repeat (8) @(negedge clk);
    blank(2);
    chk("multi_an_nopulse", 32'(vcnt - v0), 32'd0);
    dig(1, 4'h0); dig(0, 4'h9);
    chk("multi_an_value", 32'(value), 32'h4209);
    chk("multi_an_pulses", 32'(vcnt - v0), 32'd1);
    chk("multi_an_err", 32'(ecnt - e0), 32'd0);

    // Illegal glyph discards the round
    v0 = vcnt; e0 = ecnt;
    dig(3, 4'h1);
    show(2, 7'b1010101, 6);
    blank(2);
    chk("bad_err_once", 32'(ecnt - e0), 32'd1);
    chk("bad_value_hold", 32'(value), 32'h4209);
    dig(2, 4'h6); dig(1, 4'h7); dig(0, 4'h8);
    chk("bad_round_cleared", 32'(vcnt - v0), 32'd0);
    dig(3, 4'h5);
    chk("bad_next_value", 32'(value), 32'h5678);
    chk("bad_next_pulses", 32'(vcnt - v0), 32'd1);

    // Long static holds capture once
    v0 = vcnt; e0 = ecnt;
    show(2, 7'b1010101, 100);
    blank(2);
    chk("static_bad_err", 32'(ecnt - e0), 32'd1);
    show(1, gl[7], 100);
    blank(2);
    chk("static_nopulse", 32'(vcnt - v0), 32'd0);
    chk("static_noerr", 32'(ecnt - e0), 32'd1);
    dig(3, 4'hC); dig(2, 4'hD); dig(0, 4'hE);
    chk("static_value", 32'(value), 32'hCD7E);
    chk("static_pulses", 32'(vcnt - v0), 32'd1);

    // Reset mid-round discards partial captures
    dig(3, 4'h1); dig(2, 4'h2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_value", 32'(value), 32'h0);
    rst = 1'b0;
    blank(2);
    v0 = vcnt;
    dig(1, 4'hC); dig(0, 4'hD);
    chk("midrst_partial", 32'(vcnt - v0), 32'd0);
    dig(3, 4'hA); dig(2, 4'hB);
    chk("midrst_value_abcd", 32'(value), 32'hABCD);
    chk("midrst_pulses", 32'(vcnt - v0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The parameter STABLE_CYCLES SHALL default to 4 and set the consecutive identical cycles required before a digit is captured (legal 2..255).
REQ-002 The input clk SHALL be 1 bit, the single clock; all logic SHALL be rising-edge.
REQ-003 The input rst SHALL be 1 bit; reset SHALL be asynchronous and active-high.
REQ-004 The input an SHALL be 4 bits, active-low digit enables; an[i]=0 selects digit i, and digit 3 is the most significant.
REQ-005 The input seg SHALL be 7 bits, active-low segments ordered {a,b,c,d,e,f,g}, with seg[6]=a.
REQ-006 The output value SHALL be 16 bits: the last complete decoded display, digit i in value[4i+3:4i].
REQ-007 The output value_valid SHALL be 1 bit, a one-cycle pulse when value is updated.
REQ-008 The output digit_err SHALL be 1 bit, a one-cycle pulse when a captured pattern is not a legal hex glyph.

Function
REQ-009 The block SHALL act as the receiving end of the seven-segment bus: it reconstructs the hex nibbles from the multiplexed segment and anode lines.
REQ-010 A cycle SHALL be "selected" only when exactly one bit of an is 0; zero or multiple low bits SHALL be treated as blanking.
REQ-011 The FSM SHALL have three states:
- IDLE: no digit selected.
- SETTLE: a digit is selected and its pattern is being counted.
- HELD: the digit has been captured and the block waits for the bus to change.
REQ-012 In IDLE, a selected cycle SHALL move to SETTLE with the stability counter at 1, latching the an/seg pair as the reference.
REQ-013 In SETTLE, if an and seg equal the reference, the counter SHALL increment; on any difference with a selected bus, the counter SHALL restart at 1 with a new reference; on blanking, the FSM SHALL go to IDLE.
REQ-014 When the counter reaches STABLE_CYCLES, the block SHALL capture in that cycle and go to HELD.
REQ-015 In HELD, any change of an or seg SHALL be handled as a fresh entry: go to SETTLE if selected, otherwise to IDLE; no second capture SHALL occur without a change.
REQ-016 Decoding SHALL use the lit pattern (~seg), written abcdefg:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
REQ-017 On capture of a legal glyph, the nibble SHALL be written to shadow digit i and mask bit i SHALL be set.
REQ-018 Re-capture of an already-masked digit SHALL overwrite its shadow nibble without other effect.
REQ-019 On capture of an illegal glyph, digit_err SHALL pulse the cycle after capture, and mask and shadow SHALL be cleared, discarding the round.
REQ-020 When the mask becomes 4'b1111, value SHALL load the shadow including the just-captured nibble, value_valid SHALL pulse, and the mask SHALL clear; the registered outputs SHALL appear on the cycle after the capture edge.
REQ-021 Between updates, value SHALL hold its last contents.

Reset
REQ-022 While rst=1, the FSM SHALL be in IDLE and the counter, reference, shadow, mask, value, value_valid and digit_err SHALL all be 0.
REQ-023 Reset asserted mid-round SHALL discard partial captures; the first round after reset SHALL need all four digits.

Structure
REQ-024 A shared package SHALL hold the 16 glyph constants, the FSM state enumeration, and the STABLE_CYCLES default.
REQ-025 One combinational sub-module, seg7_to_hex, SHALL map the 7-bit lit pattern to a 4-bit nibble plus an illegal flag; the top SHALL instantiate it once.

Verification
REQ-026 Scan digits 3..0 showing 1,2,3,4, 8 cycles each, with 2 blanking cycles between -> value=16'h1234 and exactly one value_valid pulse per full scan.
REQ-027 Hold digit 0 with glyph 8 for 3 cycles, then switch to glyph 0 for 4 cycles (STABLE_CYCLES=4) -> only nibble 0 is captured; nibble 8 is never captured.
REQ-028 During a scan, present 1111111 lit with two anodes low -> no capture and no error; the round completes normally afterwards.
REQ-029 Digit 2 shows lit 1010101 for 6 cycles -> digit_err pulses once, and the next full scan is required before value_valid pulses.
REQ-030 Assert rst after digits 3 and 2 are captured, then scan A,b,C,d -> value=16'hABCD and value_valid pulses once, only after all four new digits.
REQ-031 Hold one digit static for 100 cycles -> exactly one capture and no repeated error or valid pulses.
